reg_file_2r1w: RTL and testbench

A 32-entry, two-read/one-write register file that supplies the A and B operands to the datapath's 32-bit operand-select muxes (select=0 takes A, select=1 takes B). It sits directly upstream of those muxes. It provides registered, one-cycle-latency reads, a hardwired-zero register 0 and a synchronous write port driven by the writeback stage.

---
 rtl/reg_file_2r1w_pkg.sv | 11 +
 rtl/reg_file_2r1w_if.sv | 27 ++
 rtl/reg_file_2r1w_read_port.sv | 59 +++++
 rtl/reg_file_2r1w.sv | 50 +++++
 tb/tb_reg_file_2r1w.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/reg_file_2r1w_pkg.sv
// Shared widths and word/address types for the register file, operand muxes and writeback stage.
package reg_file_2r1w_pkg;

    localparam int REGFILE_DATA_WIDTH = 32;
    localparam int REGFILE_ADDR_WIDTH = 5;
    localparam int REGFILE_DEPTH      = 2 ** REGFILE_ADDR_WIDTH;

    typedef logic [REGFILE_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [REGFILE_DATA_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Request/response bundle between the register file (slave) and its requester (master).
interface reg_file_2r1w_if;
    import reg_file_2r1w_pkg::*;

    logic      rd_en_a;
    reg_addr_t rd_addr_a;
    logic      rd_en_b;
    reg_addr_t rd_addr_b;
    logic      wr_en;
    reg_addr_t wr_addr;
    reg_word_t wr_data;
    reg_word_t rd_data_a;
    reg_word_t rd_data_b;
    logic      rd_valid_a;
    logic      rd_valid_b;

    modport master (
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, wr_en, wr_addr, wr_data,
        input  rd_data_a, rd_data_b, rd_valid_a, rd_valid_b
    );

    modport slave (
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, wr_en, wr_addr, wr_data,
        output rd_data_a, rd_data_b, rd_valid_a, rd_valid_b
    );

endinterface

// File: rtl/reg_file_2r1w_read_port.sv
// One registered read port: output/valid flops, register-0 force and optional write bypass.
// Write-first forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_read_port
    import reg_file_2r1w_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rd_en_i,
    input  reg_addr_t rd_addr_i,
    input  reg_word_t mem_word_i,
    input  logic      wr_en_i,
    input  reg_addr_t wr_addr_i,
    input  reg_word_t wr_data_i,
    output reg_word_t rd_data_o,
    output logic      rd_valid_o
);

    reg_word_t rd_data_q, rd_data_d;
    logic      rd_valid_q, rd_valid_d;

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (rd_en_i) begin
            rd_valid_d = 1'b1;
            if (rd_addr_i == '0) begin
                rd_data_d = '0;
            end
`ifdef REGFILE_BYPASS_EN
            else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
                rd_data_d = wr_data_i;
            end
`endif
            else begin
                rd_data_d = mem_word_i;
            end
        end
    end

`ifndef REGFILE_BYPASS_EN
    // Write-side inputs only matter when forwarding is built in.
    logic unused_bypass;
    assign unused_bypass = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// 32x32 two-read/one-write register file with hardwired-zero r0 and registered reads.
// Same-edge read of the written address returns new data when REGFILE_BYPASS_EN is defined.
module reg_file_2r1w
    import reg_file_2r1w_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    reg_file_2r1w_if.slave    rf
);

    reg_word_t mem_q [REGFILE_DEPTH];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REGFILE_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (rf.wr_en && (rf.wr_addr != '0)) begin
            mem_q[rf.wr_addr] <= rf.wr_data;
        end
    end

    regfile_read_port u_port_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en_i    (rf.rd_en_a),
        .rd_addr_i  (rf.rd_addr_a),
        .mem_word_i (mem_q[rf.rd_addr_a]),
        .wr_en_i    (rf.wr_en),
        .wr_addr_i  (rf.wr_addr),
        .wr_data_i  (rf.wr_data),
        .rd_data_o  (rf.rd_data_a),
        .rd_valid_o (rf.rd_valid_a)
    );

    regfile_read_port u_port_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en_i    (rf.rd_en_b),
        .rd_addr_i  (rf.rd_addr_b),
        .mem_word_i (mem_q[rf.rd_addr_b]),
        .wr_en_i    (rf.wr_en),
        .wr_addr_i  (rf.wr_addr),
        .wr_data_i  (rf.wr_data),
        .rd_data_o  (rf.rd_data_b),
        .rd_valid_o (rf.rd_valid_b)
    );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed, self-checking bench for reg_file_2r1w; expectations adapt to REGFILE_BYPASS_EN.
module tb_reg_file_2r1w;
    import reg_file_2r1w_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    reg_file_2r1w_if rf ();

    reg_file_2r1w dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ea, input reg_addr_t aa, input logic eb, input reg_addr_t ab,
                         input logic we, input reg_addr_t wa, input reg_word_t wd);
        rf.rd_en_a   = ea;
        rf.rd_addr_a = aa;
        rf.rd_en_b   = eb;
        rf.rd_addr_b = ab;
        rf.wr_en     = we;
        rf.wr_addr   = wa;
        rf.wr_data   = wd;
    endtask

    initial begin
        logic [31:0] exp_coll;
        n_cmp = 0;
        n_err = 0;
`ifdef REGFILE_BYPASS_EN
        exp_coll = 32'h1234_5678;
`else
        exp_coll = 32'hA5A5_A5A5;
`endif
        rst_n = 1'b0;
        drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 32'hFFFF_FFFF);
        tick();
        tick();
        check("rst_data_a", rf.rd_data_a, 32'h0);
        check("rst_data_b", rf.rd_data_b, 32'h0);
        check("rst_valid_a", {31'b0, rf.rd_valid_a}, 32'h0);
        check("rst_valid_b", {31'b0, rf.rd_valid_b}, 32'h0);

        // Reset must also have discarded the write to r7 issued during reset.
        rst_n = 1'b1;
        drive(1'b1, 5'd0, 1'b1, 5'd31, 1'b0, 5'd0, 32'h0);
        tick();
        check("post_rst_a0", rf.rd_data_a, 32'h0);
        check("post_rst_b31", rf.rd_data_b, 32'h0);
        check("post_rst_valid_a", {31'b0, rf.rd_valid_a}, 32'h1);
        check("post_rst_valid_b", {31'b0, rf.rd_valid_b}, 32'h1);

        drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        tick();
        check("rst_clears_r7", rf.rd_data_a, 32'h0);
        check("idle_valid_b", {31'b0, rf.rd_valid_b}, 32'h0);

        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'hDEAD_BEEF);
        tick();
        check("wr_only_valid_a", {31'b0, rf.rd_valid_a}, 32'h0);
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0);
        tick();
        check("rd_r7_a", rf.rd_data_a, 32'hDEAD_BEEF);
        check("rd_r0_b", rf.rd_data_b, 32'h0);

        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd31, 32'hCAFE_F00D);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd31, 1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0);
        check("rd_r31_b", rf.rd_data_b, 32'hCAFE_F00D);
        check("zero_same_edge_a", rf.rd_data_a, 32'h0);
        tick();
        check("zero_reg_a", rf.rd_data_a, 32'h0);
        check("zero_reg_b", rf.rd_data_b, 32'h0);

        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'hA5A5_A5A5);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 32'h1234_5678);
        tick();
        check("collision_a", rf.rd_data_a, exp_coll);
        check("collision_b", rf.rd_data_b, exp_coll);
        drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        tick();
        check("after_collision_a", rf.rd_data_a, 32'h1234_5678);

        drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        tick();
        check("hold_pre_a", rf.rd_data_a, 32'hDEAD_BEEF);
        drive(1'b0, 5'd7, 1'b0, 5'd0, 1'b1, 5'd7, 32'h0000_0001);
        tick();
        check("hold1_data", rf.rd_data_a, 32'hDEAD_BEEF);
        check("hold1_valid", {31'b0, rf.rd_valid_a}, 32'h0);
        drive(1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        tick();
        check("hold2_data", rf.rd_data_a, 32'hDEAD_BEEF);
        check("hold2_valid", {31'b0, rf.rd_valid_a}, 32'h0);
        tick();
        check("hold3_data", rf.rd_data_a, 32'hDEAD_BEEF);
        check("hold3_valid", {31'b0, rf.rd_valid_a}, 32'h0);
        drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        tick();
        check("hold_new_r7", rf.rd_data_a, 32'h0000_0001);

        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h0000_0055);
        tick();
        drive(1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0);
        tick();
        check("r9_a", rf.rd_data_a, 32'h0000_0055);
        check("r9_b", rf.rd_data_b, 32'h0000_0055);
        rst_n = 1'b0;
        tick();
        check("midrst_data_a", rf.rd_data_a, 32'h0);
        check("midrst_valid_a", {31'b0, rf.rd_valid_a}, 32'h0);
        check("midrst_valid_b", {31'b0, rf.rd_valid_b}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("after_rst_r9_a", rf.rd_data_a, 32'h0);
        check("after_rst_r9_b", rf.rd_data_b, 32'h0);
        check("after_rst_valid_a", {31'b0, rf.rd_valid_a}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
